// File: rtl/ctrl_pkg.sv
// Shared constants and control bundle for the ID-stage decoder.
// Opcode/funct encodings, ALU codes and field bit positions.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SEL_PC4 = 2'b00;
    localparam logic [1:0] SEL_JMP = 2'b01;
    localparam logic [1:0] SEL_REG = 2'b10;

    localparam int EXE_REG_DST   = 4;
    localparam int MEM_WR_B      = 2;
    localparam int MEM_RD_B      = 1;
    localparam int MEM_HALF_B    = 0;
    localparam int WB_REG_WR     = 1;
    localparam int WB_MEM_TO_REG = 0;

    typedef struct packed {
        logic       mem_rd_i;
        logic [1:0] sel_dir;
        logic       reset_if;
        logic       reg_rd;
        logic       sel_im;
        logic [4:0] exe;
        logic [2:0] mem;
        logic [1:0] wb;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        mem_rd_i: 1'b1, sel_dir: SEL_PC4, reset_if: 1'b0,
        reg_rd: 1'b0, sel_im: 1'b0, exe: 5'd0, mem: 3'd0, wb: 2'd0
    };

    localparam ctrl_t CTRL_RST = '{
        mem_rd_i: 1'b0, sel_dir: SEL_PC4, reset_if: 1'b1,
        reg_rd: 1'b0, sel_im: 1'b0, exe: 5'd0, mem: 3'd0, wb: 2'd0
    };

    // Register-reading ALU instruction writing its result back.
    function automatic ctrl_t alu_ctrl(
        input logic       reg_dst,
        input logic       sel_im,
        input logic [3:0] alu
    );
        ctrl_t c;
        c = CTRL_NOP;
        c.reg_rd = 1'b1;
        c.sel_im = sel_im;
        c.exe = {reg_dst, alu};
        c.wb[WB_REG_WR] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/ruta_ctrl_dec.sv
// Combinational opcode/funct decoder producing the next control bundle.
// Unknown encodings fall back to a NOP bundle.
module ruta_ctrl_dec
    import ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output ctrl_t      ctrl
);

    // Map the instruction fields onto a full control bundle
    always_comb begin
        ctrl = CTRL_NOP;
        case (opcode)
            OP_RTYPE: begin
                case (funct)
                    FN_ADD: ctrl = alu_ctrl(1'b1, 1'b0, ALU_ADD);
                    FN_SUB: ctrl = alu_ctrl(1'b1, 1'b0, ALU_SUB);
                    FN_AND: ctrl = alu_ctrl(1'b1, 1'b0, ALU_AND);
                    FN_OR:  ctrl = alu_ctrl(1'b1, 1'b0, ALU_OR);
                    FN_NOR: ctrl = alu_ctrl(1'b1, 1'b0, ALU_NOR);
                    FN_SLT: ctrl = alu_ctrl(1'b1, 1'b0, ALU_SLT);
                    FN_JR: begin
                        ctrl.sel_dir = SEL_REG;
                        ctrl.reset_if = 1'b1;
                        ctrl.reg_rd = 1'b1;
                    end
                    default: ctrl = CTRL_NOP;
                endcase
            end
            OP_ADDI: ctrl = alu_ctrl(1'b0, 1'b1, ALU_ADD);
            OP_ANDI: ctrl = alu_ctrl(1'b0, 1'b1, ALU_AND);
            OP_ORI:  ctrl = alu_ctrl(1'b0, 1'b1, ALU_OR);
            OP_SLTI: ctrl = alu_ctrl(1'b0, 1'b1, ALU_SLT);
            OP_LW: begin
                ctrl = alu_ctrl(1'b0, 1'b1, ALU_ADD);
                ctrl.mem[MEM_RD_B] = 1'b1;
                ctrl.wb[WB_MEM_TO_REG] = 1'b1;
            end
            OP_SW: begin
                ctrl = alu_ctrl(1'b0, 1'b1, ALU_ADD);
                ctrl.mem[MEM_WR_B] = 1'b1;
                ctrl.wb = 2'b00;
            end
            OP_SH: begin
                ctrl = alu_ctrl(1'b0, 1'b1, ALU_ADD);
                ctrl.mem[MEM_WR_B] = 1'b1;
                ctrl.mem[MEM_HALF_B] = 1'b1;
                ctrl.wb = 2'b00;
            end
            OP_J: begin
                ctrl.sel_dir = SEL_JMP;
                ctrl.reset_if = 1'b1;
            end
            default: ctrl = CTRL_NOP;
        endcase
    end

endmodule

// File: rtl/ruta_ctrl.sv
// ID-stage main control unit: decoder plus output register.
// Every output is registered, one cycle behind opcode/funct.
module ruta_ctrl
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       MEM_RD_I,
    output logic [1:0] SEL_DIR,
    output logic       resetIF,
    output logic       REG_RD,
    output logic       SEL_IM,
    output logic [4:0] ctrl_EXE,
    output logic [2:0] ctrl_MEM,
    output logic [1:0] ctrl_WB
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    ruta_ctrl_dec u_dec (
        .opcode (opcode),
        .funct  (funct),
        .ctrl   (ctrl_d)
    );

    // Capture the decoded bundle; reset holds fetch off and flushes IF/ID
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q <= CTRL_RST;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign MEM_RD_I = ctrl_q.mem_rd_i;
    assign SEL_DIR  = ctrl_q.sel_dir;
    assign resetIF  = ctrl_q.reset_if;
    assign REG_RD   = ctrl_q.reg_rd;
    assign SEL_IM   = ctrl_q.sel_im;
    assign ctrl_EXE = ctrl_q.exe;
    assign ctrl_MEM = ctrl_q.mem;
    assign ctrl_WB  = ctrl_q.wb;

endmodule

// File: tb/tb_ruta_ctrl.sv
// Self-checking bench for ruta_ctrl: directed steps plus random instructions
// compared against an instruction-table reference model.
module tb_ruta_ctrl;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       MEM_RD_I;
    logic [1:0] SEL_DIR;
    logic       resetIF;
    logic       REG_RD;
    logic       SEL_IM;
    logic [4:0] ctrl_EXE;
    logic [2:0] ctrl_MEM;
    logic [1:0] ctrl_WB;

    int vectors;
    int miscompares;

    ruta_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .funct    (funct),
        .MEM_RD_I (MEM_RD_I),
        .SEL_DIR  (SEL_DIR),
        .resetIF  (resetIF),
        .REG_RD   (REG_RD),
        .SEL_IM   (SEL_IM),
        .ctrl_EXE (ctrl_EXE),
        .ctrl_MEM (ctrl_MEM),
        .ctrl_WB  (ctrl_WB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view {MEM_RD_I, SEL_DIR, resetIF, REG_RD, SEL_IM, EXE, MEM, WB}
    function automatic logic [15:0] observed();
        return {MEM_RD_I, SEL_DIR, resetIF, REG_RD, SEL_IM,
                ctrl_EXE, ctrl_MEM, ctrl_WB};
    endfunction

    function automatic logic [15:0] pack(
        input logic       mrd,
        input logic [1:0] dir,
        input logic       rif,
        input logic       rrd,
        input logic       sim,
        input logic [4:0] exe,
        input logic [2:0] mem,
        input logic [1:0] wb
    );
        return {mrd, dir, rif, rrd, sim, exe, mem, wb};
    endfunction

    // Instruction-table reference: what each instruction means at the ISA level
    function automatic logic [15:0] model(
        input logic [5:0] op,
        input logic [5:0] fn
    );
        logic [15:0] nop;
        nop = pack(1, 2'b00, 0, 0, 0, 5'h00, 3'b000, 2'b00);
        if (op == 6'h00) begin
            case (fn)
                6'h20: return pack(1, 0, 0, 1, 0, 5'b1_0010, 3'b000, 2'b10);
                6'h22: return pack(1, 0, 0, 1, 0, 5'b1_0110, 3'b000, 2'b10);
                6'h24: return pack(1, 0, 0, 1, 0, 5'b1_0000, 3'b000, 2'b10);
                6'h25: return pack(1, 0, 0, 1, 0, 5'b1_0001, 3'b000, 2'b10);
                6'h27: return pack(1, 0, 0, 1, 0, 5'b1_1100, 3'b000, 2'b10);
                6'h2a: return pack(1, 0, 0, 1, 0, 5'b1_0111, 3'b000, 2'b10);
                6'h08: return pack(1, 2'b10, 1, 1, 0, 5'h00, 3'b000, 2'b00);
                default: return nop;
            endcase
        end
        case (op)
            6'h08: return pack(1, 0, 0, 1, 1, 5'b0_0010, 3'b000, 2'b10);
            6'h0c: return pack(1, 0, 0, 1, 1, 5'b0_0000, 3'b000, 2'b10);
            6'h0d: return pack(1, 0, 0, 1, 1, 5'b0_0001, 3'b000, 2'b10);
            6'h0a: return pack(1, 0, 0, 1, 1, 5'b0_0111, 3'b000, 2'b10);
            6'h23: return pack(1, 0, 0, 1, 1, 5'b0_0010, 3'b010, 2'b11);
            6'h2b: return pack(1, 0, 0, 1, 1, 5'b0_0010, 3'b100, 2'b00);
            6'h29: return pack(1, 0, 0, 1, 1, 5'b0_0010, 3'b101, 2'b00);
            6'h02: return pack(1, 2'b01, 1, 0, 0, 5'h00, 3'b000, 2'b00);
            default: return nop;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] exp);
        logic [15:0] got;
        got = observed();
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Apply one instruction away from the edge, check just after the next edge
    task automatic step(input string tag, input logic [5:0] op,
                        input logic [5:0] fn);
        @(negedge clk);
        opcode = op;
        funct = fn;
        @(posedge clk);
        #1;
        check(tag, model(op, fn));
    endtask

    logic [15:0] rst_val;
    logic [5:0]  op_tab [10];
    logic [5:0]  fn_tab [8];

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_val = pack(0, 2'b00, 1, 0, 0, 5'h00, 3'b000, 2'b00);
        op_tab = '{6'h00, 6'h00, 6'h08, 6'h0c, 6'h0d,
                   6'h0a, 6'h23, 6'h2b, 6'h29, 6'h02};
        fn_tab = '{6'h20, 6'h22, 6'h24, 6'h25,
                   6'h27, 6'h2a, 6'h08, 6'h01};

        rst = 1'b1;
        opcode = 6'h00;
        funct = 6'h20;
        #1;
        check("reset_async", rst_val);
        @(posedge clk);
        #1;
        check("reset_held", rst_val);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("first_add", 16'(pack(1, 0, 0, 1, 0, 5'b1_0010, 3'b000, 2'b10)));

        step("addi", 6'h08, 6'h3f);
        step("andi", 6'h0c, 6'h00);
        step("ori",  6'h0d, 6'h15);
        step("slti", 6'h0a, 6'h2a);
        step("lw",   6'h23, 6'h00);
        step("sw",   6'h2b, 6'h20);
        step("sh",   6'h29, 6'h08);
        step("j",    6'h02, 6'h00);
        step("j_rep", 6'h02, 6'h08);
        step("nop_after_j", 6'h3f, 6'h00);
        step("jr",   6'h00, 6'h08);
        step("add_after_jr", 6'h00, 6'h20);
        step("addi_fn_jr", 6'h08, 6'h08);
        step("bad_op", 6'h3f, 6'h20);
        step("bad_fn", 6'h00, 6'h01);
        step("sub",  6'h00, 6'h22);
        step("nor",  6'h00, 6'h27);

        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            if ($urandom_range(0, 3) == 0) begin
                op = 6'($urandom);
                fn = 6'($urandom);
            end else begin
                op = op_tab[$urandom_range(0, 9)];
                fn = fn_tab[$urandom_range(0, 7)];
            end
            step("rand", op, fn);
        end

        step("jr_pre_rst", 6'h00, 6'h08);
        #2;
        rst = 1'b1;
        #1;
        check("mid_reset", rst_val);
        @(negedge clk);
        rst = 1'b0;
        step("post_rst_and", 6'h00, 6'h24);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
